// File: rtl/simple_bus_fifo_pkg.sv
// simple_bus_fifo_pkg
// Shared constants for the simple-bus FIFO peripheral: register byte offsets,
// STATUS field positions, CTRL command bits and IRQEN enable bits.
package simple_bus_fifo_pkg;

    // Register byte offsets (word aligned)
    localparam int unsigned ADDR_DATA   = 'h00;
    localparam int unsigned ADDR_STATUS = 'h04;
    localparam int unsigned ADDR_CTRL   = 'h08;
    localparam int unsigned ADDR_THRESH = 'h0C;
    localparam int unsigned ADDR_IRQEN  = 'h10;

    // STATUS fields
    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_COUNT_W   = 9;
    localparam int unsigned STAT_EMPTY     = 16;
    localparam int unsigned STAT_FULL      = 17;
    localparam int unsigned STAT_OVERFLOW  = 18;
    localparam int unsigned STAT_UNDERFLOW = 19;
    localparam int unsigned STAT_LEVEL     = 20;

    // CTRL command bits (self-clearing)
    localparam int unsigned CTRL_FLUSH = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    // IRQEN bits
    localparam int unsigned IRQEN_LEVEL = 0;
    localparam int unsigned IRQEN_ERR   = 1;

    localparam int unsigned THRESH_W = 9;

endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core
// Single-clock FIFO: storage, head/tail pointers and occupancy count.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, push_data  enqueue request and word (dropped when full unless popping)
//   pop           dequeue request (ignored when empty)
//   flush         empty the FIFO; wins over push and pop
//   head          word at the read pointer (undefined when empty)
//   count         occupancy, clog2(DEPTH)+1 bits
//   full, empty   occupancy flags
module sync_fifo_core #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage is not reset; contents are only observed through a valid count.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/simple_bus_fifo_regs.sv
// simple_bus_fifo_regs
// Register-mapped FIFO on the simple bus: DATA push/pop, STATUS, CTRL
// (flush / clear sticky), THRESH and IRQEN, with a registered level interrupt.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   wrAddr, wrData, wr         write byte address, data, one-cycle strobe
//   rdAddr, rd                 read byte address, read-active level
//   rdData                     combinational read data
//   irq                        registered level interrupt
module simple_bus_fifo_regs #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData,
    input  logic                  rd,
    output logic                  irq
);

    import simple_bus_fifo_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]           wr_off, rd_off, rd_addr_off;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  end_of_read, rd_data_end;
    logic                  wr_data, wr_ctrl, wr_thresh, wr_irqen;
    logic                  push, pop, flush, clr;
    logic                  ovf_set, unf_set;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic [THRESH_W-1:0]   thresh_q;
    logic [1:0]            irqen_q;
    logic                  irq_q, irq_d, level;
    logic [DATA_WIDTH-1:0] head;
    logic [CNT_W-1:0]      count;
    logic                  full, empty;

    // Word offsets; byte lanes within a word are ignored.
    assign wr_off      = 32'(wrAddr) & ~32'd3;
    assign rd_off      = 32'(rdAddr) & ~32'd3;
    assign rd_addr_off = 32'(rd_addr_q) & ~32'd3;

    assign wr_data   = wr && (wr_off == ADDR_DATA);
    assign wr_ctrl   = wr && (wr_off == ADDR_CTRL);
    assign wr_thresh = wr && (wr_off == ADDR_THRESH);
    assign wr_irqen  = wr && (wr_off == ADDR_IRQEN);

    // Read side effects fire once, when the rd window closes, using the
    // address captured when it opened.
    assign end_of_read = rd_q & ~rd;
    assign rd_data_end = end_of_read && (rd_addr_off == ADDR_DATA);

    assign push    = wr_data;
    assign pop     = rd_data_end & ~empty;
    assign flush   = wr_ctrl & wrData[CTRL_FLUSH];
    assign clr     = wr_ctrl & wrData[CTRL_CLEAR];
    assign ovf_set = wr_data & full & ~pop;
    assign unf_set = rd_data_end & empty;

    // A new error in the same cycle as a clear keeps the flag set.
    assign overflow_d  = (overflow_q & ~clr) | ovf_set;
    assign underflow_d = (underflow_q & ~clr) | unf_set;

    assign level = (THRESH_W'(count) >= thresh_q);
    assign irq_d = (irqen_q[IRQEN_LEVEL] & level) |
                   (irqen_q[IRQEN_ERR] & (overflow_q | underflow_q));
    assign irq   = irq_q;

    sync_fifo_core #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .push      (push),
        .push_data (wrData),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_q        <= 1'b0;
            rd_addr_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            thresh_q    <= THRESH_W'(DEPTH / 2);
            irqen_q     <= 2'b00;
            irq_q       <= 1'b0;
        end else begin
            rd_q        <= rd;
            if (rd && !rd_q) rd_addr_q <= rdAddr;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (wr_thresh) thresh_q <= wrData[THRESH_W-1:0];
            if (wr_irqen)  irqen_q  <= wrData[1:0];
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        rdData = '0;
        case (rd_off)
            ADDR_DATA: begin
                if (!empty) rdData = head;
            end
            ADDR_STATUS: begin
                rdData[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
                rdData[STAT_EMPTY]                     = empty;
                rdData[STAT_FULL]                      = full;
                rdData[STAT_OVERFLOW]                  = overflow_q;
                rdData[STAT_UNDERFLOW]                 = underflow_q;
                rdData[STAT_LEVEL]                     = level;
            end
            ADDR_THRESH: rdData[THRESH_W-1:0] = thresh_q;
            ADDR_IRQEN:  rdData[1:0]          = irqen_q;
            default:     rdData = '0;
        endcase
    end

endmodule

// File: tb/tb_simple_bus_fifo_regs.sv
module tb_simple_bus_fifo_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic        wr = 1'b0, rd = 1'b0, irq;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] q[$];
    bit          m_ovf, m_unf;
    int          m_thresh = 8;
    bit [1:0]    m_irqen;

    always #5 clk = ~clk;

    simple_bus_fifo_regs #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .DEPTH      (16)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .wrAddr        (wr_addr),
        .wrData        (wr_data),
        .wr            (wr),
        .rdAddr        (rd_addr),
        .rdData        (rd_data),
        .rd            (rd),
        .irq           (irq)
    );

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int n;
        n = q.size();
        s = 32'(n);
        s[16] = (n == 0);
        s[17] = (n == 16);
        s[18] = m_ovf;
        s[19] = m_unf;
        s[20] = (n >= m_thresh);
        return s;
    endfunction

    function automatic logic m_irq();
        return (m_irqen[0] && (q.size() >= m_thresh)) || (m_irqen[1] && (m_ovf || m_unf));
    endfunction

    function automatic logic [31:0] m_read_val(input int a);
        case (a & ~3)
            'h00:    return (q.size() > 0) ? q[0] : 32'h0;
            'h04:    return m_status();
            'h0C:    return 32'(m_thresh);
            'h10:    return {30'b0, m_irqen};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_thresh = 8;
        m_irqen = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write on the bus and apply the same rules to the model.
    task automatic m_wr(input int a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        @(negedge clk);
        wr = 1'b0;
        case (a & ~3)
            'h00: if (q.size() < 16) q.push_back(d); else m_ovf = 1;
            'h08: begin
                if (d[0]) q.delete();
                if (d[1]) begin m_ovf = 0; m_unf = 0; end
            end
            'h0C: m_thresh = int'(d[8:0]);
            'h10: m_irqen = d[1:0];
            default: ;
        endcase
    endtask

    // Read held for 'hold' cycles; rdData must be stable throughout.
    task automatic m_rd(input int a, input int hold, input string tag);
        logic [31:0] exp, got;
        exp = m_read_val(a);
        @(negedge clk);
        rd = 1'b1;
        rd_addr = 6'(a);
        #1 got = rd_data;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            #1 chk({tag, "_stable"}, rd_data, got);
        end
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        chk(tag, got, exp);
        if ((a & ~3) == 0) begin
            if (q.size() > 0) void'(q.pop_front()); else m_unf = 1;
        end
    endtask

    initial begin
        logic [31:0] got, exp;
        int r;

        // Reset state
        idle(3);
        rst_n = 1'b1;
        chk("reset_irq", {31'b0, irq}, 32'h0);
        m_rd('h04, 1, "reset_status");
        m_rd('h0C, 1, "reset_thresh");
        m_rd('h10, 1, "reset_irqen");

        // Basic push / pop order
        m_wr('h00, 32'hA1);
        m_wr('h00, 32'hB2);
        m_wr('h00, 32'hC3);
        m_rd('h04, 1, "status3");
        m_rd('h00, 1, "pop_a1");
        m_rd('h00, 1, "pop_b2");
        m_rd('h00, 1, "pop_c3");
        m_rd('h04, 1, "status_empty");

        // Long read window pops exactly once
        m_wr('h00, 32'h11);
        m_wr('h00, 32'h22);
        m_rd('h00, 5, "hold5");
        m_rd('h00, 1, "after_hold");
        m_rd('h04, 1, "status_after_hold");

        // Overflow
        for (int i = 0; i < 17; i++) m_wr('h00, 32'(i));
        m_rd('h04, 1, "status_full_ovf");
        for (int i = 0; i < 16; i++) m_rd('h00, 1, "drain");
        m_wr('h08, 32'h2);

        // Underflow and error interrupt
        m_rd('h00, 1, "empty_read");
        m_rd('h04, 1, "status_unf");
        m_wr('h10, 32'h2);
        idle(1);
        chk("irq_err", {31'b0, irq}, {31'b0, m_irq()});
        m_wr('h08, 32'h2);
        chk("irq_clear_lag", {31'b0, irq}, 32'h1);
        idle(1);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        // Level interrupt latency
        m_wr('h0C, 32'h4);
        m_wr('h10, 32'h1);
        for (int i = 0; i < 3; i++) m_wr('h00, 32'h50 + 32'(i));
        idle(1);
        chk("irq_below", {31'b0, irq}, 32'h0);
        m_wr('h00, 32'h53);
        chk("irq_lag", {31'b0, irq}, 32'h0);
        idle(1);
        chk("irq_level", {31'b0, irq}, 32'h1);
        m_rd('h00, 1, "level_pop");
        chk("irq_pop_lag", {31'b0, irq}, 32'h1);
        idle(1);
        chk("irq_level_drop", {31'b0, irq}, 32'h0);
        m_wr('h08, 32'h1);
        m_rd('h04, 1, "status_flushed");

        // Randomised traffic
        m_wr('h10, 32'h3);
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 11);
            if (r <= 3)       m_wr('h00, $urandom);
            else if (r <= 6)  m_rd('h00, $urandom_range(1, 3), "rnd_data");
            else if (r == 7)  m_rd('h04, 1, "rnd_status");
            else if (r == 8)  m_rd(4 * $urandom_range(0, 15) + $urandom_range(0, 3), 1, "rnd_any");
            else if (r == 9)  m_wr('h08, (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0) |
                                         (($urandom_range(0, 1) == 0) ? 32'h2 : 32'h0));
            else if (r == 10) m_wr('h0C, 32'($urandom_range(0, 17)));
            else              m_wr(4 * $urandom_range(5, 15), $urandom);
            idle(1);
            chk("rnd_irq", {31'b0, irq}, {31'b0, m_irq()});
        end

        // Full FIFO: push coinciding with the end-of-read pop
        m_wr('h08, 32'h3);
        m_wr('h10, 32'h0);
        m_wr('h0C, 32'h8);
        for (int i = 0; i < 16; i++) m_wr('h00, 32'h100 + 32'(i));
        exp = q[0];
        @(negedge clk);
        rd = 1'b1;
        rd_addr = 6'h00;
        #1 got = rd_data;
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b1;
        wr_addr = 6'h00;
        wr_data = 32'hBEEF;
        @(negedge clk);
        wr = 1'b0;
        chk("pushpop_head", got, exp);
        void'(q.pop_front());
        q.push_back(32'hBEEF);
        m_rd('h04, 1, "pushpop_status");
        for (int i = 0; i < 16; i++) m_rd('h00, 1, "pushpop_order");
        for (int i = 0; i < 5; i++) m_wr('h00, 32'h200 + 32'(i));
        m_wr('h08, 32'h3);
        m_rd('h04, 1, "flush_status");
        m_rd('h00, 1, "flush_data");

        // Reset during a read window
        m_wr('h0C, 32'h1);
        m_wr('h10, 32'h3);
        m_wr('h00, 32'h77);
        m_wr('h00, 32'h88);
        idle(1);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        rd = 1'b1;
        rd_addr = 6'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("reset_async_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        m_rd('h04, 1, "rst_status");
        m_rd('h0C, 1, "rst_thresh");
        m_rd('h10, 1, "rst_irqen");
        chk("rst_irq", {31'b0, irq}, 32'h0);
        m_rd('h00, 1, "rst_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
